cpu_sram_responder: RTL and testbench
=====================================

Name: cpu_sram_responder

Overview:
- Target side of the CPU SRAM-style inst/data interfaces: answers the core's fetch and load/store requests with fixed one-cycle read latency.
- Backs both ports with one unified word memory.
- Decodes a small configuration-register window on the data port: LED, number display, switches, timer.
- Sits in the SoC top beside the CPU core and replaces the separate inst/data RAM models in simulation and FPGA builds.

Parameters:
ADDR_W, 16, word-index width; memory depth = 2^ADDR_W 32-bit words
CONF_BASE, 32'hbfaf_0000, base of the config window; matched on addr[31:16]

Ports:
clk  in  1  clock
resetn  in  1  reset, asynchronous, active-low
inst_sram_en  in  1  fetch request valid
inst_sram_wen  in  4  byte write enables; ignored (port is read-only)
inst_sram_addr  in  32  byte address of fetch
inst_sram_wdata  in  32  ignored
inst_sram_rdata  out  32  fetched word, one cycle after request
data_sram_en  in  1  data request valid
data_sram_wen  in  4  byte write enables; 0 = read
data_sram_addr  in  32  byte address
data_sram_wdata  in  32  store data, byte lanes aligned to wen
data_sram_rdata  out  32  load word, one cycle after request
conf_switch  in  8  board switches, asynchronous to clk
conf_led  out  16  LED register
conf_num  out  32  number-display register

Behaviour:
- Reset (resetn low, async): inst_sram_rdata=0, data_sram_rdata=0, conf_led=0, conf_num=0, timer=0, switch synchroniser=0. Memory array is not reset.
- Request acceptance: every cycle with en=1 is one request. There is no backpressure and no stall.
- Read latency: rdata is registered from the address sampled on the en=1 edge and is valid the following cycle.
- en=0: rdata holds its previous value.
- Memory index is addr[ADDR_W+1:2]. Upper bits outside the config window alias (wrap). addr[1:0] is ignored.
- Data write (en=1, wen!=0):
  - Byte lane i is written when wen[i]=1.
  - data_sram_rdata on the following cycle returns the old word (read-first).
  - A read of the same word in the next cycle returns the new word.
- Inst read and data write to the same word in the same cycle: inst_sram_rdata returns the old word (read-first).
- Config decode applies when data_sram_addr[31:16]==CONF_BASE[31:16]. Offset is addr[15:0]. Config accesses never touch memory.
  - 0x0000 LED: RW. Byte wen honoured on bits [15:0]; upper lanes ignored. Reads zero-extended.
  - 0x0004 NUM: RW, byte wen honoured.
  - 0x0008 SWITCH: RO. Reads {24'b0, 2-flop-synchronised conf_switch}. Writes ignored.
  - 0x000C TIMER: see Optional Feature.
  - Any other offset: reads 0, writes ignored.
- Config reads also have one-cycle latency. A read returns the register value before any write in the same cycle.
- Inst port never decodes the config window. Inst addresses always index memory, aliasing as above.
- Reset asserted mid-access: outputs clear immediately. A request sampled in the same cycle as reset release is ignored.

Optional Feature:
- Macro: CPU_SRAM_TIMER_EN.
- Defined: TIMER is a 32-bit free-running counter, +1 every clk, wrapping 0xFFFF_FFFF -> 0.
  - A write to 0x000C loads the full 32-bit wdata (all four wen lanes required; partial wen ignored).
  - The loaded value appears the next cycle, and incrementing resumes from it on the cycle after.
  - A read returns the counter value at the sampling edge.
- Not defined: no counter flops. 0x000C reads 0 and writes are ignored.

Decomposition:
- Package cpu_sram_pkg holds CONF_BASE_HI (16'hbfaf) and the offset constants CONF_LED_OFF, CONF_NUM_OFF, CONF_SW_OFF, CONF_TIMER_OFF.
- One sub-module, sram_byte_bank: 2^ADDR_W x 32 array with one read-only port and one read-first byte-write port, both with registered outputs.
- The top holds the config decode, the config registers, the timer and the rdata mux.

Test Plan:
- Reset then idle: conf_led=0, conf_num=0, both rdata=0. With en=0 after a read, rdata stays constant.
- Byte write: data write addr 0x100, wen=4'b0101, wdata 0xAABBCCDD over prior 0x11223344 -> next read of 0x100 returns 0x11BB33DD.
- Collision: data write 0xDEADBEEF to 0x200 while inst reads 0x200 in the same cycle -> inst_sram_rdata shows the old word. Inst read of 0x200 in the next cycle -> 0xDEADBEEF.
- Config window:
  - Write 0x0000FFFF to 0xbfaf0000 -> conf_led=16'hFFFF.
  - conf_switch=8'h5A, then read 0xbfaf0008 -> 0x0000005A no earlier than 3 cycles after the switch change.
  - Read 0xbfaf0040 -> 0.
- Timer (macro defined):
  - Write 0xFFFFFFFE to 0xbfaf000C.
  - Back-to-back reads starting 2 cycles later return 0xFFFFFFFF, then 0x00000000.
  - Without the macro the same reads return 0.
- Async reset mid-run: pull resetn low during a read request -> both rdata clear immediately. Memory word 0x100 still reads 0x11BB33DD after release.

Source files
------------

// File: rtl/cpu_sram_responder_pkg.sv
// cpu_sram_pkg: config window constants and byte-lane merge helper for cpu_sram_responder
package cpu_sram_pkg;
   localparam logic [15:0] CONF_BASE_HI   = 16'hbfaf;
   localparam logic [15:0] CONF_LED_OFF   = 16'h0000;
   localparam logic [15:0] CONF_NUM_OFF   = 16'h0004;
   localparam logic [15:0] CONF_SW_OFF    = 16'h0008;
   localparam logic [15:0] CONF_TIMER_OFF = 16'h000c;

   function automatic logic [31:0] byte_merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                              input logic [3:0] wen);
      logic [31:0] r;
      r = old_w;
      for (int b = 0; b < 4; b++) if (wen[b]) r[8*b +: 8] = new_w[8*b +: 8];
      return r;
   endfunction
endpackage

// File: rtl/cpu_sram_responder_if.sv
// cpu_sram_responder_if: SRAM-style inst/data bus between CPU core (master) and responder (slave)
interface cpu_sram_responder_if;
   logic        inst_sram_en;
   logic [3:0]  inst_sram_wen;
   logic [31:0] inst_sram_addr;
   logic [31:0] inst_sram_wdata;
   logic [31:0] inst_sram_rdata;
   logic        data_sram_en;
   logic [3:0]  data_sram_wen;
   logic [31:0] data_sram_addr;
   logic [31:0] data_sram_wdata;
   logic [31:0] data_sram_rdata;

   modport master (
      output inst_sram_en, inst_sram_wen, inst_sram_addr, inst_sram_wdata,
      output data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
      input  inst_sram_rdata, data_sram_rdata
   );

   modport slave (
      input  inst_sram_en, inst_sram_wen, inst_sram_addr, inst_sram_wdata,
      input  data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
      output inst_sram_rdata, data_sram_rdata
   );
endinterface

// File: rtl/sram_byte_bank.sv
// sram_byte_bank: 2^ADDR_W x 32 word array, one read port and one read-first byte-write port, registered outputs
module sram_byte_bank #(
   parameter int ADDR_W = 16
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              rd_en_i,
   input  logic [ADDR_W-1:0] rd_addr_i,
   output logic [31:0]       rd_data_o,
   input  logic              rw_en_i,
   input  logic [3:0]        rw_wen_i,
   input  logic [ADDR_W-1:0] rw_addr_i,
   input  logic [31:0]       rw_wdata_i,
   output logic [31:0]       rw_data_o
);
   logic [31:0] mem [2**ADDR_W];
   logic [31:0] rd_data_q, rw_data_q;

   // byte-lane writes; the array itself is never reset
   always_ff @(posedge clk) begin
      if (rw_en_i)
         for (int b = 0; b < 4; b++)
            if (rw_wen_i[b]) mem[rw_addr_i][8*b +: 8] <= rw_wdata_i[8*b +: 8];
   end

   // registered reads see the pre-write word and hold while idle
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rd_data_q <= '0;
         rw_data_q <= '0;
      end else begin
         rd_data_q <= rd_en_i ? mem[rd_addr_i] : rd_data_q;
         rw_data_q <= rw_en_i ? mem[rw_addr_i] : rw_data_q;
      end
   end

   assign rd_data_o = rd_data_q;
   assign rw_data_o = rw_data_q;
endmodule

// File: rtl/cpu_sram_responder.sv
// cpu_sram_responder: unified-memory target for CPU inst/data SRAM ports with config window (timer under CPU_SRAM_TIMER_EN)
module cpu_sram_responder
   import cpu_sram_pkg::*;
#(
   parameter int          ADDR_W    = 16,
   parameter logic [31:0] CONF_BASE = {CONF_BASE_HI, 16'h0000}
) (
   input  logic                 clk,
   input  logic                 resetn,
   cpu_sram_responder_if.slave  bus,
   input  logic [7:0]           conf_switch,
   output logic [15:0]          conf_led,
   output logic [31:0]          conf_num
);
   logic        live_q;
   logic        inst_req, data_req, conf_hit, conf_req, mem_req, conf_wr;
   logic [15:0] off;
   logic [31:0] wdata;
   logic [31:0] led_merge, num_merge, timer_val;
   logic [15:0] led_q, led_d;
   logic [31:0] num_q, num_d;
   logic [7:0]  sw_meta_q, sw_sync_q;
   logic [31:0] conf_rdata_q, conf_rdata_d;
   logic        sel_conf_q;
   logic [31:0] bank_inst_rdata, bank_data_rdata;
   logic        unused_bits;

   assign unused_bits = ^{bus.inst_sram_wen, bus.inst_sram_wdata, bus.inst_sram_addr, bus.data_sram_addr};

   // blocks the request sampled on the edge that follows reset release
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) live_q <= 1'b0;
      else         live_q <= 1'b1;
   end

   assign inst_req  = bus.inst_sram_en & live_q;
   assign data_req  = bus.data_sram_en & live_q;
   assign conf_hit  = bus.data_sram_addr[31:16] == CONF_BASE[31:16];
   assign conf_req  = data_req & conf_hit;
   assign mem_req   = data_req & ~conf_hit;
   assign conf_wr   = conf_req & |bus.data_sram_wen;
   assign off       = bus.data_sram_addr[15:0];
   assign wdata     = bus.data_sram_wdata;
   assign led_merge = byte_merge({16'h0000, led_q}, wdata, {2'b00, bus.data_sram_wen[1:0]});
   assign num_merge = byte_merge(num_q, wdata, bus.data_sram_wen);

   sram_byte_bank #(.ADDR_W(ADDR_W)) u_bank (
      .clk        (clk),
      .resetn     (resetn),
      .rd_en_i    (inst_req),
      .rd_addr_i  (bus.inst_sram_addr[ADDR_W+1:2]),
      .rd_data_o  (bank_inst_rdata),
      .rw_en_i    (mem_req),
      .rw_wen_i   (bus.data_sram_wen),
      .rw_addr_i  (bus.data_sram_addr[ADDR_W+1:2]),
      .rw_wdata_i (wdata),
      .rw_data_o  (bank_data_rdata)
   );

`ifdef CPU_SRAM_TIMER_EN
   logic [31:0] timer_q, timer_d;

   // free-running counter; a full-word write loads it, counting resumes from the loaded value
   always_comb begin
      timer_d = (conf_wr && off == CONF_TIMER_OFF && bus.data_sram_wen == 4'hf) ? wdata : timer_q + 32'd1;
   end

   // timer state
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) timer_q <= '0;
      else         timer_q <= timer_d;
   end

   assign timer_val = timer_q;
`else
   assign timer_val = '0;
`endif

   // register writes and read-mux for the config window
   always_comb begin
      led_d        = (conf_wr && off == CONF_LED_OFF) ? led_merge[15:0] : led_q;
      num_d        = (conf_wr && off == CONF_NUM_OFF) ? num_merge : num_q;
      conf_rdata_d = off == CONF_LED_OFF   ? {16'h0000, led_q} :
                     off == CONF_NUM_OFF   ? num_q :
                     off == CONF_SW_OFF    ? {24'h000000, sw_sync_q} :
                     off == CONF_TIMER_OFF ? timer_val : 32'h0;
   end

   // config registers, switch synchroniser and data-side read select
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         led_q        <= '0;
         num_q        <= '0;
         sw_meta_q    <= '0;
         sw_sync_q    <= '0;
         conf_rdata_q <= '0;
         sel_conf_q   <= 1'b0;
      end else begin
         led_q        <= led_d;
         num_q        <= num_d;
         sw_meta_q    <= conf_switch;
         sw_sync_q    <= sw_meta_q;
         conf_rdata_q <= conf_req ? conf_rdata_d : conf_rdata_q;
         sel_conf_q   <= data_req ? conf_hit : sel_conf_q;
      end
   end

   assign bus.inst_sram_rdata = bank_inst_rdata;
   assign bus.data_sram_rdata = sel_conf_q ? conf_rdata_q : bank_data_rdata;
   assign conf_led            = led_q;
   assign conf_num            = num_q;
endmodule

// File: tb/tb_cpu_sram_responder.sv
// tb_cpu_sram_responder: directed-vector bench for cpu_sram_responder (expectations follow CPU_SRAM_TIMER_EN)
module tb_cpu_sram_responder;
   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic [7:0]  conf_switch = 8'h00;
   logic [15:0] conf_led;
   logic [31:0] conf_num;
   int          n_vec = 0;
   int          n_err = 0;

   cpu_sram_responder_if bus();

   cpu_sram_responder dut (
      .clk         (clk),
      .resetn      (resetn),
      .bus         (bus),
      .conf_switch (conf_switch),
      .conf_led    (conf_led),
      .conf_num    (conf_num)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.inst_sram_en = 1'b0;
      bus.data_sram_en = 1'b0;
      bus.data_sram_wen = 4'h0;
   endtask

   task automatic dwrite(input logic [31:0] a, input logic [3:0] w, input logic [31:0] d);
      bus.data_sram_en = 1'b1;
      bus.data_sram_wen = w;
      bus.data_sram_addr = a;
      bus.data_sram_wdata = d;
      cyc();
      idle();
   endtask

   task automatic dread(input logic [31:0] a);
      bus.data_sram_en = 1'b1;
      bus.data_sram_wen = 4'h0;
      bus.data_sram_addr = a;
      cyc();
      idle();
   endtask

   task automatic iread(input logic [31:0] a);
      bus.inst_sram_en = 1'b1;
      bus.inst_sram_addr = a;
      cyc();
      idle();
   endtask

   initial begin
      logic [31:0] tmr_a, tmr_b;
`ifdef CPU_SRAM_TIMER_EN
      tmr_a = 32'hffff_ffff;
      tmr_b = 32'h0000_0000;
`else
      tmr_a = 32'h0;
      tmr_b = 32'h0;
`endif
      bus.inst_sram_wen = 4'h0;
      bus.inst_sram_wdata = 32'h0;
      bus.inst_sram_addr = 32'h0;
      bus.data_sram_addr = 32'h0;
      bus.data_sram_wdata = 32'h0;
      idle();
      cyc();
      cyc();
      check("rst_led", {16'h0, conf_led}, 32'h0);
      check("rst_num", conf_num, 32'h0);
      check("rst_irdata", bus.inst_sram_rdata, 32'h0);
      check("rst_drdata", bus.data_sram_rdata, 32'h0);
      resetn = 1'b1;
      cyc();

      dwrite(32'h0000_0100, 4'hf, 32'h1122_3344);
      dwrite(32'h0000_0100, 4'b0101, 32'haabb_ccdd);
      check("wr_read_first", bus.data_sram_rdata, 32'h1122_3344);
      dread(32'h0000_0100);
      check("byte_wr", bus.data_sram_rdata, 32'h11bb_33dd);
      cyc();
      cyc();
      check("hold_en0", bus.data_sram_rdata, 32'h11bb_33dd);

      dwrite(32'h0000_0200, 4'hf, 32'h0101_0101);
      bus.inst_sram_en = 1'b1;
      bus.inst_sram_addr = 32'h0000_0200;
      dwrite(32'h0000_0200, 4'hf, 32'hdead_beef);
      check("collide_old", bus.inst_sram_rdata, 32'h0101_0101);
      iread(32'h0000_0200);
      check("collide_new", bus.inst_sram_rdata, 32'hdead_beef);
      iread(32'h0004_0200);
      check("inst_alias", bus.inst_sram_rdata, 32'hdead_beef);
      dread(32'h0000_0203);
      check("data_lowbits", bus.data_sram_rdata, 32'hdead_beef);

      dwrite(32'hbfaf_0000, 4'hf, 32'h0000_ffff);
      check("led_full", {16'h0, conf_led}, 32'h0000_ffff);
      dwrite(32'hbfaf_0000, 4'b0001, 32'h1234_5678);
      check("led_byte", {16'h0, conf_led}, 32'h0000_ff78);
      dwrite(32'hbfaf_0000, 4'b1100, 32'h1234_5678);
      check("led_upper_ign", {16'h0, conf_led}, 32'h0000_ff78);
      dread(32'hbfaf_0000);
      check("led_read", bus.data_sram_rdata, 32'h0000_ff78);
      dwrite(32'hbfaf_0004, 4'hf, 32'hcafe_f00d);
      dwrite(32'hbfaf_0004, 4'b0010, 32'h0000_5500);
      check("num_byte", conf_num, 32'hcafe_550d);
      dread(32'hbfaf_0004);
      check("num_read", bus.data_sram_rdata, 32'hcafe_550d);

      conf_switch = 8'h5a;
      cyc();
      cyc();
      cyc();
      dread(32'hbfaf_0008);
      check("switch", bus.data_sram_rdata, 32'h0000_005a);
      dwrite(32'hbfaf_0008, 4'hf, 32'h0);
      dread(32'hbfaf_0008);
      check("switch_ro", bus.data_sram_rdata, 32'h0000_005a);

      dwrite(32'h0003_0040, 4'hf, 32'h1357_9bdf);
      dwrite(32'hbfaf_0040, 4'hf, 32'h7777_7777);
      check("conf_wr_rdata", bus.data_sram_rdata, 32'h0);
      dread(32'hbfaf_0040);
      check("conf_hole", bus.data_sram_rdata, 32'h0);
      dread(32'h0003_0040);
      check("conf_no_mem", bus.data_sram_rdata, 32'h1357_9bdf);

      dwrite(32'hbfaf_000c, 4'hf, 32'hffff_fffe);
      cyc();
      dread(32'hbfaf_000c);
      check("timer_a", bus.data_sram_rdata, tmr_a);
      dread(32'hbfaf_000c);
      check("timer_b", bus.data_sram_rdata, tmr_b);

      dread(32'h0000_0100);
      iread(32'h0000_0200);
      check("pre_rst_d", bus.data_sram_rdata, 32'h11bb_33dd);
      check("pre_rst_i", bus.inst_sram_rdata, 32'hdead_beef);
      bus.data_sram_en = 1'b1;
      bus.data_sram_addr = 32'h0000_0100;
      bus.inst_sram_en = 1'b1;
      bus.inst_sram_addr = 32'h0000_0200;
      #2;
      resetn = 1'b0;
      #1;
      check("async_rst_d", bus.data_sram_rdata, 32'h0);
      check("async_rst_i", bus.inst_sram_rdata, 32'h0);
      check("async_rst_led", {16'h0, conf_led}, 32'h0);
      idle();
      cyc();
      resetn = 1'b1;
      dwrite(32'h0000_0100, 4'hf, 32'h9999_9999);
      dread(32'h0000_0100);
      check("mem_kept", bus.data_sram_rdata, 32'h11bb_33dd);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
